csr_stream_host: RTL and testbench

//  Host-side sequencer for the sparse MVM accelerator link. Holds one CSR matrix
//  (up to 16 non-zeros) plus a 4-bit spike train. On `go` it streams both to the

---
 rtl/csr_stream_host_pkg.sv | 46 ++++
 rtl/csr_stream_host_entry_buf.sv | 35 +++
 rtl/csr_stream_host.sv | 227 ++++++++++++++++++++++
 tb/tb_csr_stream_host.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_stream_host_pkg.sv
// ---------------------------------------------------------------------------
// csr_stream_host_pkg
//   Shared definitions for the CSR stream host and the sparse MVM accelerator:
//   buffer geometry, CSR field widths, run parameters, sequencer state
//   encoding and the packed CSR entry layout.
//   No ports (package).
// ---------------------------------------------------------------------------
package csr_stream_host_pkg;

   localparam int NNZ_MAX    = 16;
   localparam int ADDR_W     = 4;
   localparam int NNZ_W      = 5;
   localparam int ROW_W      = 2;
   localparam int COL_W      = 2;
   localparam int VAL_W      = 8;
   localparam int SPIKE_W    = 4;
   localparam int N_ROWS     = 4;
   localparam int CNT_W      = 3;
   localparam int FRAME_SKIP = 1;
   localparam int TIMEOUT    = 1023;
   localparam int TMR_W      = 10;

   typedef struct packed {
      logic [ROW_W-1:0] row;
      logic [COL_W-1:0] col;
      logic [VAL_W-1:0] val;
   } csr_entry_t;

   typedef enum logic [3:0] {
      S_IDLE       = 4'd0,
      S_START      = 4'd1,
      S_WAIT_RDY   = 4'd2,
      S_BEAT       = 4'd3,
      S_GAP        = 4'd4,
      S_LIST_END   = 4'd5,
      S_TRAIN_RDY  = 4'd6,
      S_TRAIN_BEAT = 4'd7,
      S_COLLECT    = 4'd8
   } state_t;

   // A request for more entries than the buffer holds sends the whole buffer.
   function automatic logic [NNZ_W-1:0] clamp_nnz(input logic [NNZ_W-1:0] n);
      return (n > NNZ_W'(NNZ_MAX)) ? NNZ_W'(NNZ_MAX) : n;
   endfunction

endpackage

// File: rtl/csr_stream_host_entry_buf.sv
// ---------------------------------------------------------------------------
// csr_entry_buf
//   16 x 12-bit register file holding the CSR non-zeros {row, col, value}.
//   One synchronous write port, one asynchronous read port.
//   Ports:
//     i_clk    clock
//     i_we     write enable
//     i_waddr  write index
//     i_wdata  entry to store
//     i_raddr  read index
//     o_rdata  entry at i_raddr (combinational)
// ---------------------------------------------------------------------------
module csr_entry_buf
   import csr_stream_host_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  csr_entry_t        i_wdata,
   input  logic [ADDR_W-1:0] i_raddr,
   output csr_entry_t        o_rdata
);

   csr_entry_t r_mem [NNZ_MAX];

   // Storage only; contents are meaningful once the CPU has written them.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/csr_stream_host.sv
// ---------------------------------------------------------------------------
// csr_stream_host
//   Host-side sequencer for the sparse MVM accelerator link. Streams the CSR
//   buffer and a spike train to the accelerator, then collects N_ROWS result
//   bytes framed by toggles of i_acc_sending_out.
//   Ports:
//     i_clk, i_rst_n                 clock, async active-low reset
//     i_wr_en/addr/row/col/val       CSR buffer write (dropped while busy)
//     i_nnz, i_spike_train, i_go     run request, sampled on accepted go
//     o_busy, o_done, o_error        run status (done = 1-cycle pulse)
//     o_results                      row r in bits [8r+7:8r]
//     o_acc_*                        registered outputs to the accelerator
//     i_acc_fetch_ready              accelerator can take a beat
//     i_acc_output_val/sending_out   result byte and its framing toggle
//     o_dbg_state                    current sequencer state
//
//   Handshake: a beat (o_acc_sending_cpu) or end-of-list (o_acc_done_list)
//   strobe is raised for exactly one cycle, and only after
//   i_acc_fetch_ready was seen high at the preceding clock edge; at least one
//   strobe-free cycle separates strobes so a ready that the accelerator has
//   not yet dropped cannot launch a second beat. Data outputs keep their last
//   value while strobes are low.
// ---------------------------------------------------------------------------
module csr_stream_host
   import csr_stream_host_pkg::*;
(
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_wr_en,
   input  logic [ADDR_W-1:0]      i_wr_addr,
   input  logic [ROW_W-1:0]       i_wr_row,
   input  logic [COL_W-1:0]       i_wr_col,
   input  logic [VAL_W-1:0]       i_wr_val,
   input  logic [NNZ_W-1:0]       i_nnz,
   input  logic [SPIKE_W-1:0]     i_spike_train,
   input  logic                   i_go,
   output logic                   o_busy,
   output logic                   o_done,
   output logic                   o_error,
   output logic [N_ROWS*VAL_W-1:0] o_results,
   output logic                   o_acc_start,
   output logic [ROW_W-1:0]       o_acc_row_val,
   output logic [COL_W-1:0]       o_acc_column_val,
   output logic [VAL_W-1:0]       o_acc_value,
   output logic                   o_acc_sending_cpu,
   output logic                   o_acc_done_list,
   input  logic                   i_acc_fetch_ready,
   input  logic [VAL_W-1:0]       i_acc_output_val,
   input  logic                   i_acc_sending_out,
   output state_t                 o_dbg_state
);

   state_t                  r_state;
   logic [NNZ_W-1:0]        r_nnz;
   logic [NNZ_W-1:0]        r_idx;
   logic [SPIKE_W-1:0]      r_spike;
   logic [CNT_W-1:0]        r_cnt;
   logic [CNT_W-1:0]        r_skip;
   logic [TMR_W-1:0]        r_tmr;
   logic                    r_prev;
   logic                    r_busy, r_done, r_error;
   logic                    r_start, r_sending, r_done_list;
   logic [ROW_W-1:0]        r_row;
   logic [COL_W-1:0]        r_col;
   logic [VAL_W-1:0]        r_value;
   logic [N_ROWS*VAL_W-1:0] r_results;

   csr_entry_t w_entry;
   csr_entry_t w_wdata;
   logic       w_toggle;
   logic       w_tmr_expired;

   assign w_wdata       = '{row: i_wr_row, col: i_wr_col, val: i_wr_val};
   assign w_toggle      = i_acc_sending_out ^ r_prev;
   assign w_tmr_expired = (r_tmr == TMR_W'(TIMEOUT - 1));

   csr_entry_buf u_buf (
      .i_clk   (i_clk),
      .i_we    (i_wr_en & ~r_busy),
      .i_waddr (i_wr_addr),
      .i_wdata (w_wdata),
      .i_raddr (r_idx[ADDR_W-1:0]),
      .o_rdata (w_entry)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= S_IDLE;
         r_nnz       <= '0;
         r_idx       <= '0;
         r_spike     <= '0;
         r_cnt       <= '0;
         r_skip      <= '0;
         r_tmr       <= '0;
         r_prev      <= i_acc_sending_out;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_error     <= 1'b0;
         r_start     <= 1'b0;
         r_sending   <= 1'b0;
         r_done_list <= 1'b0;
         r_row       <= '0;
         r_col       <= '0;
         r_value     <= '0;
         r_results   <= '0;
      end else begin
         // Toggle history is tracked in every state so a toggle seen before
         // COLLECT is absorbed rather than counted later.
         r_prev <= i_acc_sending_out;
         r_done <= 1'b0;
         // Timer restarts on any state change; wait states override below.
         r_tmr  <= '0;
         unique case (r_state)
            S_IDLE: begin
               if (i_go) begin
                  r_nnz   <= clamp_nnz(i_nnz);
                  r_spike <= i_spike_train;
                  r_error <= 1'b0;
                  r_cnt   <= '0;
                  r_skip  <= '0;
                  r_idx   <= '0;
                  r_busy  <= 1'b1;
                  r_start <= 1'b1;
                  r_state <= S_START;
               end
            end
            S_START: begin
               r_start <= 1'b0;
               r_state <= (r_nnz == '0) ? S_LIST_END : S_WAIT_RDY;
            end
            S_WAIT_RDY: begin
               if (i_acc_fetch_ready) begin
                  r_sending <= 1'b1;
                  r_row     <= w_entry.row;
                  r_col     <= w_entry.col;
                  r_value   <= w_entry.val;
                  r_state   <= S_BEAT;
               end else if (w_tmr_expired) begin
                  r_error <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_tmr <= r_tmr + 1'b1;
               end
            end
            S_BEAT: begin
               r_sending <= 1'b0;
               r_idx     <= r_idx + 1'b1;
               r_state   <= S_GAP;
            end
            S_GAP: begin
               r_state <= (r_idx == r_nnz) ? S_LIST_END : S_WAIT_RDY;
            end
            S_LIST_END: begin
               if (i_acc_fetch_ready) begin
                  r_done_list <= 1'b1;
                  r_state     <= S_TRAIN_RDY;
               end else if (w_tmr_expired) begin
                  r_error <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_tmr <= r_tmr + 1'b1;
               end
            end
            S_TRAIN_RDY: begin
               // The cycle carrying done_list doubles as the mandatory gap.
               r_done_list <= 1'b0;
               if (i_acc_fetch_ready && !r_done_list) begin
                  r_sending <= 1'b1;
                  r_row     <= '0;
                  r_col     <= '0;
                  r_value   <= {{(VAL_W-SPIKE_W){1'b0}}, r_spike};
                  r_state   <= S_TRAIN_BEAT;
               end else if (w_tmr_expired) begin
                  r_error <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_tmr <= r_tmr + 1'b1;
               end
            end
            S_TRAIN_BEAT: begin
               r_sending <= 1'b0;
               r_state   <= S_COLLECT;
            end
            S_COLLECT: begin
               if (w_toggle) begin
                  if (r_skip < CNT_W'(FRAME_SKIP)) begin
                     r_skip <= r_skip + 1'b1;
                  end else begin
                     r_results[{r_cnt[1:0], 3'b000} +: VAL_W] <= i_acc_output_val;
                     r_cnt <= r_cnt + 1'b1;
                     if (r_cnt == CNT_W'(N_ROWS - 1)) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                     end
                  end
               end else if (w_tmr_expired) begin
                  r_error <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_tmr <= r_tmr + 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign o_busy            = r_busy;
   assign o_done            = r_done;
   assign o_error           = r_error;
   assign o_results         = r_results;
   assign o_acc_start       = r_start;
   assign o_acc_row_val     = r_row;
   assign o_acc_column_val  = r_col;
   assign o_acc_value       = r_value;
   assign o_acc_sending_cpu = r_sending;
   assign o_acc_done_list   = r_done_list;
   assign o_dbg_state       = r_state;

endmodule

// File: tb/tb_csr_stream_host.sv
// ---------------------------------------------------------------------------
// tb_csr_stream_host
//   Directed bench for csr_stream_host. A negedge monitor records strobe
//   timing and checks each beat against an expected queue; the main initial
//   block walks through the directed runs and checks status, timing and
//   results against hand-computed values.
// ---------------------------------------------------------------------------
module tb_csr_stream_host;
   import csr_stream_host_pkg::*;

   logic        clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic        i_wr_en = 1'b0;
   logic [3:0]  i_wr_addr = '0;
   logic [1:0]  i_wr_row = '0;
   logic [1:0]  i_wr_col = '0;
   logic [7:0]  i_wr_val = '0;
   logic [4:0]  i_nnz = '0;
   logic [3:0]  i_spike_train = '0;
   logic        i_go = 1'b0;
   logic        i_acc_fetch_ready = 1'b1;
   logic [7:0]  i_acc_output_val = '0;
   logic        i_acc_sending_out = 1'b0;
   logic        o_busy, o_done, o_error;
   logic [31:0] o_results;
   logic        o_acc_start, o_acc_sending_cpu, o_acc_done_list;
   logic [1:0]  o_acc_row_val, o_acc_column_val;
   logic [7:0]  o_acc_value;
   state_t      o_dbg_state;

   int          n_vec = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          st_cyc = 0;
   int          dl_cyc = 0;
   int          n_beats = 0, n_dl = 0, n_start = 0, n_done = 0;
   int          beat_cyc[$];
   logic [11:0] exp_q[$];

   csr_stream_host dut (
      .i_clk             (clk),
      .i_rst_n           (i_rst_n),
      .i_wr_en           (i_wr_en),
      .i_wr_addr         (i_wr_addr),
      .i_wr_row          (i_wr_row),
      .i_wr_col          (i_wr_col),
      .i_wr_val          (i_wr_val),
      .i_nnz             (i_nnz),
      .i_spike_train     (i_spike_train),
      .i_go              (i_go),
      .o_busy            (o_busy),
      .o_done            (o_done),
      .o_error           (o_error),
      .o_results         (o_results),
      .o_acc_start       (o_acc_start),
      .o_acc_row_val     (o_acc_row_val),
      .o_acc_column_val  (o_acc_column_val),
      .o_acc_value       (o_acc_value),
      .o_acc_sending_cpu (o_acc_sending_cpu),
      .o_acc_done_list   (o_acc_done_list),
      .i_acc_fetch_ready (i_acc_fetch_ready),
      .i_acc_output_val  (i_acc_output_val),
      .i_acc_sending_out (i_acc_sending_out),
      .o_dbg_state       (o_dbg_state)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #300000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- driver / check tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [3:0] a, input logic [1:0] r, input logic [1:0] c, input logic [7:0] v);
      i_wr_addr = a; i_wr_row = r; i_wr_col = c; i_wr_val = v; i_wr_en = 1'b1;
      step();
      i_wr_en = 1'b0;
   endtask

   task automatic start_run(input logic [4:0] n, input logic [3:0] s, input string tag);
      i_nnz = n; i_spike_train = s; i_go = 1'b1;
      step();
      i_go = 1'b0;
      chk({tag, "_start"}, {30'd0, o_acc_start, o_busy}, 32'd3);
   endtask

   task automatic wait_state(input state_t s, input int lim, input string tag);
      int n = 0;
      while (o_dbg_state !== s && n < lim) begin
         step();
         n++;
      end
      chk(tag, 32'(o_dbg_state), 32'(s));
   endtask

   // First byte of b is the framing byte that must be discarded.
   task automatic collect(input logic [39:0] b, input logic [31:0] exp_res, input string tag);
      wait_state(S_COLLECT, 200, {tag, "_enter_collect"});
      for (int i = 0; i < 4; i++) begin
         i_acc_output_val  = b[8*i +: 8];
         i_acc_sending_out = ~i_acc_sending_out;
         step();
         step();
      end
      chk({tag, "_partial"}, {8'd0, o_results[23:0]}, {8'd0, exp_res[23:0]});
      chk({tag, "_done_early"}, 32'(o_done), 32'd0);
      i_acc_output_val  = b[39:32];
      i_acc_sending_out = ~i_acc_sending_out;
      step();
      chk({tag, "_done"}, {30'd0, o_done, o_busy}, 32'd2);
      chk({tag, "_results"}, o_results, exp_res);
      step();
      chk({tag, "_done_1cyc"}, 32'(o_done), 32'd0);
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      if (i_rst_n) begin
         if (o_acc_sending_cpu) begin
            beat_cyc.push_back(cyc);
            n_beats++;
            chk("beat_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0)
               chk("beat_data", {20'd0, o_acc_row_val, o_acc_column_val, o_acc_value},
                   {20'd0, exp_q.pop_front()});
         end
         if (o_acc_done_list) begin dl_cyc = cyc; n_dl++; end
         if (o_acc_start)     begin st_cyc = cyc; n_start++; end
         if (o_done)          n_done++;
      end
   end

   // ---------------- directed sequence ----------------
   initial begin
      int b, n, saw, base_beats, base_dl, base_start, base_done;

      // Reset state
      step(); step();
      chk("rst_status", {29'd0, o_busy, o_done, o_error}, 32'd0);
      chk("rst_results", o_results, 32'd0);
      chk("rst_strobes", {29'd0, o_acc_start, o_acc_sending_cpu, o_acc_done_list}, 32'd0);
      chk("rst_value", 32'(o_acc_value), 32'd0);
      chk("rst_state", 32'(o_dbg_state), 32'(S_IDLE));
      i_rst_n = 1'b1;
      step();

      // T1: three entries, ready held high; T4 collection folded in
      wr(4'd0, 2'd0, 2'd1, 8'd5);
      wr(4'd1, 2'd1, 2'd2, 8'd7);
      wr(4'd2, 2'd3, 2'd0, 8'd2);
      exp_q.push_back({2'd0, 2'd1, 8'd5});
      exp_q.push_back({2'd1, 2'd2, 8'd7});
      exp_q.push_back({2'd3, 2'd0, 8'd2});
      exp_q.push_back({2'd0, 2'd0, 8'h0F});
      b = beat_cyc.size();
      start_run(5'd3, 4'hF, "t1");
      wait_state(S_COLLECT, 100, "t1_reach_collect");
      chk("t1_beat_count", 32'(beat_cyc.size() - b), 32'd4);
      chk("t1_start_to_beat0", 32'(beat_cyc[b] - st_cyc), 32'd2);
      chk("t1_beat0_to_beat1", 32'(beat_cyc[b+1] - beat_cyc[b]), 32'd3);
      chk("t1_beat1_to_beat2", 32'(beat_cyc[b+2] - beat_cyc[b+1]), 32'd3);
      chk("t1_beat2_to_dlist", 32'(dl_cyc - beat_cyc[b+2]), 32'd3);
      chk("t1_dlist_to_train", 32'(beat_cyc[b+3] - dl_cyc), 32'd2);
      collect(40'h44332211AA, 32'h44332211, "t4");

      // T2: ready low for five cycles after the first beat
      exp_q.push_back({2'd0, 2'd1, 8'd5});
      exp_q.push_back({2'd1, 2'd2, 8'd7});
      exp_q.push_back({2'd3, 2'd0, 8'd2});
      exp_q.push_back({2'd0, 2'd0, 8'h05});
      start_run(5'd3, 4'h5, "t2");
      n = 0;
      while (!o_acc_sending_cpu && n < 20) begin step(); n++; end
      chk("t2_first_beat", 32'(o_acc_sending_cpu), 32'd1);
      i_acc_fetch_ready = 1'b0;
      // write while busy must be dropped
      i_wr_addr = 4'd0; i_wr_row = 2'd2; i_wr_col = 2'd2; i_wr_val = 8'h99; i_wr_en = 1'b1;
      saw = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         i_wr_en = 1'b0;
         if (o_acc_sending_cpu) saw = 1;
      end
      chk("t2_no_beat_while_low", 32'(saw), 32'd0);
      i_acc_fetch_ready = 1'b1;
      step();
      chk("t2_beat_after_rise", {23'd0, o_acc_sending_cpu, o_acc_value}, {23'd0, 1'b1, 8'd7});
      collect(40'hD4C3B2A1FF, 32'hD4C3B2A1, "t2");

      // T3: nnz = 0, plus go while busy
      exp_q.push_back({2'd0, 2'd0, 8'h0A});
      base_beats = n_beats; base_dl = n_dl; base_start = n_start;
      start_run(5'd0, 4'hA, "t3");
      i_go = 1'b1;
      step();
      i_go = 1'b0;
      collect(40'h04030201EE, 32'h04030201, "t3");
      chk("t3_beats", 32'(n_beats - base_beats), 32'd1);
      chk("t3_dlist", 32'(n_dl - base_dl), 32'd1);
      chk("t3_single_start", 32'(n_start - base_start), 32'd1);

      // T5: one entry (proves the busy write was dropped), then no toggles
      exp_q.push_back({2'd0, 2'd1, 8'd5});
      exp_q.push_back({2'd0, 2'd0, 8'h0C});
      base_done = n_done;
      start_run(5'd1, 4'hC, "t5");
      wait_state(S_COLLECT, 100, "t5_reach_collect");
      n = 0;
      while (!o_error && n < 1100) begin step(); n++; end
      chk("t5_timeout_cycles", 32'(n), 32'd1023);
      chk("t5_error_idle", {30'd0, o_error, o_busy}, 32'd2);
      chk("t5_state", 32'(o_dbg_state), 32'(S_IDLE));
      chk("t5_no_done", 32'(n_done - base_done), 32'd0);
      chk("t5_results_kept", o_results, 32'h04030201);

      // T6: go with a same-cycle write, then reset during the first beat
      i_wr_addr = 4'd0; i_wr_row = 2'd1; i_wr_col = 2'd3; i_wr_val = 8'h66; i_wr_en = 1'b1;
      start_run(5'd3, 4'h1, "t6");
      i_wr_en = 1'b0;
      chk("t6_error_cleared", 32'(o_error), 32'd0);
      n = 0;
      while (!o_acc_sending_cpu && n < 20) begin step(); n++; end
      chk("t6_beat_new_entry", {20'd0, o_acc_row_val, o_acc_column_val, o_acc_value},
          {20'd0, 2'd1, 2'd3, 8'h66});
      exp_q.delete();
      #1 i_rst_n = 1'b0;
      #1;
      chk("t6_rst_strobes", {29'd0, o_acc_start, o_acc_sending_cpu, o_acc_done_list}, 32'd0);
      chk("t6_rst_busy", 32'(o_busy), 32'd0);
      step(); step();
      i_rst_n = 1'b1;
      step();

      // T7: nnz above capacity sends all sixteen entries
      for (int i = 0; i < 16; i++) begin
         wr(4'(i), 2'(i), 2'(i >> 2), 8'(8'h10 + i));
         exp_q.push_back({2'(i), 2'(i >> 2), 8'(8'h10 + i)});
      end
      exp_q.push_back({2'd0, 2'd0, 8'h03});
      base_beats = n_beats;
      start_run(5'd20, 4'h3, "t7");
      collect(40'h4030201000, 32'h40302010, "t7");
      chk("t7_beats_clamped", 32'(n_beats - base_beats), 32'd17);
      chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
